// File: rtl/seq_shift_add_multiplier_if.sv
// rtl/seq_shift_add_multiplier_if.sv - start/done handshake and operand/product bundle for the shift-add multiplier
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   y;

    modport master (output start, output a, output b, input busy, input done, input y);
    modport slave  (input start, input a, input b, output busy, output done, output y);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - iterative unsigned WIDTH x WIDTH shift-add multiplier, one multiplier bit per clock
// Optional EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    seq_shift_add_multiplier_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   y_reg;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        count;
    logic                 last_iter;
    logic                 accept;
    logic                 busy_int;
    logic                 done_int;

    // acc_sum already includes this edge's partial product, so it is the value committed to y
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef EARLY_TERM_EN
    assign last_iter = (count == LAST) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_iter = (count == LAST);
`endif

    always_comb begin
        state_next = state;
        busy_int   = 1'b0;
        done_int   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                done_int = (state == DONE);
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                busy_int = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            y_reg  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                mcand  <= {{WIDTH{1'b0}}, bus.a};
                mplier <= bus.b;
                acc    <= '0;
                count  <= '0;
            end else if (state == RUN) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
                if (last_iter) begin
                    y_reg <= acc_sum;
                end
            end
        end
    end

    assign bus.busy = busy_int;
    assign bus.done = done_int;
    assign bus.y    = y_reg;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - directed-vector bench for seq_shift_add_multiplier at WIDTH=2 and WIDTH=8
module tb_seq_shift_add_multiplier;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   cyc;

    seq_shift_add_multiplier_if #(.WIDTH(2)) m2 ();
    seq_shift_add_multiplier_if #(.WIDTH(8)) m8 ();

    seq_shift_add_multiplier #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(m2.slave));
    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(m8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_cycles(input int bv, input int w);
`ifdef EARLY_TERM_EN
        int m;
        m = 1;
        for (int i = 0; i < w; i++) begin
            if (bv[i]) m = i + 1;
        end
        return m;
`else
        return w + (bv & 0);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mul8(input string tag, input int av, input int bv);
        int n;
        m8.a = 8'(av);
        m8.b = 8'(bv);
        m8.start = 1'b1;
        step();
        m8.start = 1'b0;
        n = 0;
        while (m8.busy && n < 100) begin
            n++;
            step();
        end
        check({tag, "_cycles"}, 64'(n), 64'(exp_cycles(bv, 8)));
        check({tag, "_done"}, 64'(m8.done), 64'd1);
        check({tag, "_busy_low"}, 64'(m8.busy), 64'd0);
        check({tag, "_y"}, 64'(m8.y), 64'(av * bv));
        step();
        check({tag, "_done_pulse"}, 64'(m8.done), 64'd0);
        check({tag, "_y_held"}, 64'(m8.y), 64'(av * bv));
    endtask

    task automatic mul2(input int av, input int bv);
        int n;
        m2.a = 2'(av);
        m2.b = 2'(bv);
        m2.start = 1'b1;
        step();
        m2.start = 1'b0;
        n = 0;
        while (m2.busy && n < 20) begin
            n++;
            step();
        end
        check($sformatf("w2_%0dx%0d_cycles", av, bv), 64'(n), 64'(exp_cycles(bv, 2)));
        check($sformatf("w2_%0dx%0d_y", av, bv), 64'(m2.y & {64{m2.done}}), 64'(av * bv));
        step();
    endtask

    initial begin : stim
        int n;
        int t;
        int last_done;
        bit seen;
        int va[3];
        int vb[3];
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        m2.start = 1'b0; m2.a = '0; m2.b = '0;
        m8.start = 1'b0; m8.a = '0; m8.b = '0;
        step();
        step();
        check("rst_busy", 64'(m8.busy), 64'd0);
        check("rst_done", 64'(m8.done), 64'd0);
        check("rst_y", 64'(m8.y), 64'd0);
        check("rst_y_w2", 64'(m2.y), 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                mul2(i, j);
            end
        end

        mul8("max", 255, 255);
        repeat (3) step();
        check("max_y_stable", 64'(m8.y), 64'd65025);

        // second start mid-RUN must not disturb operands
        m8.a = 8'd12; m8.b = 8'd10; m8.start = 1'b1;
        step();
        n = 0;
        while (m8.busy && n < 100) begin
            if (n == 3) begin
                m8.start = 1'b1; m8.a = 8'd1; m8.b = 8'd1;
            end else begin
                m8.start = 1'b0;
            end
            n++;
            step();
        end
        m8.start = 1'b0;
        check("ignore_cycles", 64'(n), 64'(exp_cycles(10, 8)));
        check("ignore_done", 64'(m8.done), 64'd1);
        check("ignore_y", 64'(m8.y), 64'd120);
        step();

        m8.a = 8'd200; m8.b = 8'd3; m8.start = 1'b1;
        step();
        m8.start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 64'(m8.busy), 64'd0);
        check("abort_done", 64'(m8.done), 64'd0);
        check("abort_y", 64'(m8.y), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen |= m8.done;
            step();
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_y_after", 64'(m8.y), 64'd0);

        va = '{7, 255, 16};
        vb = '{9, 1, 16};
        m8.a = 8'(va[0]); m8.b = 8'(vb[0]); m8.start = 1'b1;
        last_done = 0;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!m8.done && t < 50) begin
                step();
                t++;
            end
            check($sformatf("b2b%0d_done", k), 64'(m8.done), 64'd1);
            check($sformatf("b2b%0d_y", k), 64'(m8.y), 64'(va[k] * vb[k]));
            if (k > 0) begin
                check($sformatf("b2b%0d_period", k), 64'(cyc - last_done), 64'(exp_cycles(vb[k], 8) + 1));
            end
            last_done = cyc;
            if (k < 2) begin
                m8.a = 8'(va[k+1]); m8.b = 8'(vb[k+1]);
            end else begin
                m8.start = 1'b0;
            end
            step();
        end
        step();

        mul8("b1", 77, 1);
        mul8("b0", 77, 0);
        mul8("b128", 77, 128);
        mul8("mixed", 171, 205);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
